// File: rtl/mig_axi_port_arbiter.sv
// N:1 AXI4 arbiter sharing the MIG slave port: independent round-robin write and read FSMs,
// one outstanding burst per direction, locally generated WLAST with sticky mismatch flags.
module mig_axi_port_arbiter #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ID_W      = 4
) (
    input  logic                          mig_ui_clk,
    input  logic                          mig_ui_rst,
    // Upstream write address
    input  logic [NUM_PORTS*ID_W-1:0]     s_awid_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]   s_awaddr_i,
    input  logic [NUM_PORTS*8-1:0]        s_awlen_i,
    input  logic [NUM_PORTS*3-1:0]        s_awsize_i,
    input  logic [NUM_PORTS*2-1:0]        s_awburst_i,
    input  logic [NUM_PORTS-1:0]          s_awvalid_i,
    output logic [NUM_PORTS-1:0]          s_awready_o,
    // Upstream write data
    input  logic [NUM_PORTS*DATA_W-1:0]   s_wdata_i,
    input  logic [NUM_PORTS*DATA_W/8-1:0] s_wstrb_i,
    input  logic [NUM_PORTS-1:0]          s_wlast_i,
    input  logic [NUM_PORTS-1:0]          s_wvalid_i,
    output logic [NUM_PORTS-1:0]          s_wready_o,
    // Upstream write response
    output logic [ID_W-1:0]               s_bid_o,
    output logic [1:0]                    s_bresp_o,
    output logic [NUM_PORTS-1:0]          s_bvalid_o,
    input  logic [NUM_PORTS-1:0]          s_bready_i,
    // Upstream read address
    input  logic [NUM_PORTS*ID_W-1:0]     s_arid_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]   s_araddr_i,
    input  logic [NUM_PORTS*8-1:0]        s_arlen_i,
    input  logic [NUM_PORTS*3-1:0]        s_arsize_i,
    input  logic [NUM_PORTS*2-1:0]        s_arburst_i,
    input  logic [NUM_PORTS-1:0]          s_arvalid_i,
    output logic [NUM_PORTS-1:0]          s_arready_o,
    // Upstream read data
    output logic [ID_W-1:0]               s_rid_o,
    output logic [DATA_W-1:0]             s_rdata_o,
    output logic [1:0]                    s_rresp_o,
    output logic                          s_rlast_o,
    output logic [NUM_PORTS-1:0]          s_rvalid_o,
    input  logic [NUM_PORTS-1:0]          s_rready_i,
    // MIG write address
    output logic [ID_W-1:0]               mig_s_axi_awid_o,
    output logic [ADDR_W-1:0]             mig_s_axi_awaddr_o,
    output logic [7:0]                    mig_s_axi_awlen_o,
    output logic [2:0]                    mig_s_axi_awsize_o,
    output logic [1:0]                    mig_s_axi_awburst_o,
    output logic                          mig_s_axi_awlock_o,
    output logic [3:0]                    mig_s_axi_awcache_o,
    output logic [2:0]                    mig_s_axi_awprot_o,
    output logic [3:0]                    mig_s_axi_awqos_o,
    output logic                          mig_s_axi_awvalid_o,
    input  logic                          mig_s_axi_awready_i,
    // MIG write data
    output logic [DATA_W-1:0]             mig_s_axi_wdata_o,
    output logic [DATA_W/8-1:0]           mig_s_axi_wstrb_o,
    output logic                          mig_s_axi_wlast_o,
    output logic                          mig_s_axi_wvalid_o,
    input  logic                          mig_s_axi_wready_i,
    // MIG write response
    input  logic [ID_W-1:0]               mig_s_axi_bid_i,
    input  logic [1:0]                    mig_s_axi_bresp_i,
    input  logic                          mig_s_axi_bvalid_i,
    output logic                          mig_s_axi_bready_o,
    // MIG read address
    output logic [ID_W-1:0]               mig_s_axi_arid_o,
    output logic [ADDR_W-1:0]             mig_s_axi_araddr_o,
    output logic [7:0]                    mig_s_axi_arlen_o,
    output logic [2:0]                    mig_s_axi_arsize_o,
    output logic [1:0]                    mig_s_axi_arburst_o,
    output logic                          mig_s_axi_arlock_o,
    output logic [3:0]                    mig_s_axi_arcache_o,
    output logic [2:0]                    mig_s_axi_arprot_o,
    output logic [3:0]                    mig_s_axi_arqos_o,
    output logic                          mig_s_axi_arvalid_o,
    input  logic                          mig_s_axi_arready_i,
    // MIG read data
    input  logic [ID_W-1:0]               mig_s_axi_rid_i,
    input  logic [DATA_W-1:0]             mig_s_axi_rdata_i,
    input  logic [1:0]                    mig_s_axi_rresp_i,
    input  logic                          mig_s_axi_rlast_i,
    input  logic                          mig_s_axi_rvalid_i,
    output logic                          mig_s_axi_rready_o,
    // Status
    output logic [NUM_PORTS-1:0]          err_wlast_o,
    output logic                          wr_busy_o,
    output logic                          rd_busy_o
);

    localparam int unsigned StrbW = DATA_W / 8;
    localparam int unsigned PtrW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {WIdle, WAddr, WData, WResp} w_state_e;
    typedef enum logic [1:0] {RIdle, RAddr, RData} r_state_e;

    w_state_e              w_state_q;
    r_state_e              r_state_q;
    logic [PtrW-1:0]       wg_q, rg_q, wr_ptr_q, rd_ptr_q;
    logic [7:0]            wlen_q, wcnt_q;
    logic [NUM_PORTS-1:0]  err_q;

    // First requester strictly after ptr, wrapping modulo NUM_PORTS.
    function automatic logic [PtrW-1:0] rr_pick(input logic [PtrW-1:0] ptr,
                                                input logic [NUM_PORTS-1:0] req);
        logic [PtrW-1:0] sel;
        logic            found;
        int unsigned     idx;
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            idx = (32'(ptr) + i) % NUM_PORTS;
            if (!found && req[idx]) begin
                sel   = PtrW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    logic w_last, aw_hs, w_hs, b_hs, ar_hs, r_done;

    assign w_last = (wcnt_q == wlen_q);
    assign aw_hs  = (w_state_q == WAddr) && s_awvalid_i[wg_q] && mig_s_axi_awready_i;
    assign w_hs   = (w_state_q == WData) && s_wvalid_i[wg_q] && mig_s_axi_wready_i;
    assign b_hs   = (w_state_q == WResp) && mig_s_axi_bvalid_i && s_bready_i[wg_q];
    assign ar_hs  = (r_state_q == RAddr) && s_arvalid_i[rg_q] && mig_s_axi_arready_i;
    assign r_done = (r_state_q == RData) && mig_s_axi_rvalid_i && s_rready_i[rg_q]
                    && mig_s_axi_rlast_i;

    always_ff @(posedge mig_ui_clk or posedge mig_ui_rst) begin
        if (mig_ui_rst) begin
            w_state_q <= WIdle;
            wg_q      <= '0;
            wr_ptr_q  <= PtrW'(NUM_PORTS - 1);
            wlen_q    <= '0;
            wcnt_q    <= '0;
            err_q     <= '0;
        end else begin
            case (w_state_q)
                WIdle: if (|s_awvalid_i) begin
                    wg_q      <= rr_pick(wr_ptr_q, s_awvalid_i);
                    w_state_q <= WAddr;
                end
                WAddr: if (aw_hs) begin
                    wlen_q    <= s_awlen_i[wg_q*8 +: 8];
                    wcnt_q    <= '0;
                    w_state_q <= WData;
                end
                WData: if (w_hs) begin
                    wcnt_q <= wcnt_q + 8'd1;
                    if (s_wlast_i[wg_q] != w_last) err_q[wg_q] <= 1'b1;
                    if (w_last) w_state_q <= WResp;
                end
                WResp: if (b_hs) begin
                    wr_ptr_q  <= wg_q;
                    w_state_q <= WIdle;
                end
                default: w_state_q <= WIdle;
            endcase
        end
    end

    always_ff @(posedge mig_ui_clk or posedge mig_ui_rst) begin
        if (mig_ui_rst) begin
            r_state_q <= RIdle;
            rg_q      <= '0;
            rd_ptr_q  <= PtrW'(NUM_PORTS - 1);
        end else begin
            case (r_state_q)
                RIdle: if (|s_arvalid_i) begin
                    rg_q      <= rr_pick(rd_ptr_q, s_arvalid_i);
                    r_state_q <= RAddr;
                end
                RAddr: if (ar_hs) r_state_q <= RData;
                RData: if (r_done) begin
                    rd_ptr_q  <= rg_q;
                    r_state_q <= RIdle;
                end
                default: r_state_q <= RIdle;
            endcase
        end
    end

    always_comb begin
        s_awready_o         = '0;
        s_wready_o          = '0;
        s_bvalid_o          = '0;
        mig_s_axi_awid_o    = '0;
        mig_s_axi_awaddr_o  = '0;
        mig_s_axi_awlen_o   = '0;
        mig_s_axi_awsize_o  = '0;
        mig_s_axi_awburst_o = '0;
        mig_s_axi_awvalid_o = 1'b0;
        mig_s_axi_wdata_o   = '0;
        mig_s_axi_wstrb_o   = '0;
        mig_s_axi_wlast_o   = 1'b0;
        mig_s_axi_wvalid_o  = 1'b0;
        mig_s_axi_bready_o  = 1'b0;
        case (w_state_q)
            WAddr: begin
                mig_s_axi_awvalid_o = s_awvalid_i[wg_q];
                mig_s_axi_awid_o    = s_awid_i[wg_q*ID_W +: ID_W];
                mig_s_axi_awaddr_o  = s_awaddr_i[wg_q*ADDR_W +: ADDR_W];
                mig_s_axi_awlen_o   = s_awlen_i[wg_q*8 +: 8];
                mig_s_axi_awsize_o  = s_awsize_i[wg_q*3 +: 3];
                mig_s_axi_awburst_o = s_awburst_i[wg_q*2 +: 2];
                s_awready_o[wg_q]   = mig_s_axi_awready_i;
            end
            WData: begin
                mig_s_axi_wvalid_o = s_wvalid_i[wg_q];
                mig_s_axi_wdata_o  = s_wdata_i[wg_q*DATA_W +: DATA_W];
                mig_s_axi_wstrb_o  = s_wstrb_i[wg_q*StrbW +: StrbW];
                mig_s_axi_wlast_o  = w_last;
                s_wready_o[wg_q]   = mig_s_axi_wready_i;
            end
            WResp: begin
                s_bvalid_o[wg_q]   = mig_s_axi_bvalid_i;
                mig_s_axi_bready_o = s_bready_i[wg_q];
            end
            default: ;
        endcase
    end

    always_comb begin
        s_arready_o         = '0;
        s_rvalid_o          = '0;
        mig_s_axi_arid_o    = '0;
        mig_s_axi_araddr_o  = '0;
        mig_s_axi_arlen_o   = '0;
        mig_s_axi_arsize_o  = '0;
        mig_s_axi_arburst_o = '0;
        mig_s_axi_arvalid_o = 1'b0;
        mig_s_axi_rready_o  = 1'b0;
        case (r_state_q)
            RAddr: begin
                mig_s_axi_arvalid_o = s_arvalid_i[rg_q];
                mig_s_axi_arid_o    = s_arid_i[rg_q*ID_W +: ID_W];
                mig_s_axi_araddr_o  = s_araddr_i[rg_q*ADDR_W +: ADDR_W];
                mig_s_axi_arlen_o   = s_arlen_i[rg_q*8 +: 8];
                mig_s_axi_arsize_o  = s_arsize_i[rg_q*3 +: 3];
                mig_s_axi_arburst_o = s_arburst_i[rg_q*2 +: 2];
                s_arready_o[rg_q]   = mig_s_axi_arready_i;
            end
            RData: begin
                s_rvalid_o[rg_q]   = mig_s_axi_rvalid_i;
                mig_s_axi_rready_o = s_rready_i[rg_q];
            end
            default: ;
        endcase
    end

    assign mig_s_axi_awlock_o  = 1'b0;
    assign mig_s_axi_awcache_o = 4'b0011;
    assign mig_s_axi_awprot_o  = 3'b000;
    assign mig_s_axi_awqos_o   = 4'b0000;
    assign mig_s_axi_arlock_o  = 1'b0;
    assign mig_s_axi_arcache_o = 4'b0011;
    assign mig_s_axi_arprot_o  = 3'b000;
    assign mig_s_axi_arqos_o   = 4'b0000;

    assign s_bid_o   = mig_s_axi_bid_i;
    assign s_bresp_o = mig_s_axi_bresp_i;
    assign s_rid_o   = mig_s_axi_rid_i;
    assign s_rdata_o = mig_s_axi_rdata_i;
    assign s_rresp_o = mig_s_axi_rresp_i;
    assign s_rlast_o = mig_s_axi_rlast_i;

    assign err_wlast_o = err_q;
    assign wr_busy_o   = (w_state_q != WIdle);
    assign rd_busy_o   = (r_state_q != RIdle);

endmodule

// File: tb/tb_mig_axi_port_arbiter.sv
// Randomized bench for mig_axi_port_arbiter: bench-side masters and MIG slave, with a
// transaction-level round-robin model predicting grant order, routing and WLAST errors.
module tb_mig_axi_port_arbiter;
    localparam int N = 3;

    logic clk = 1'b0;
    logic mig_ui_rst;
    always #5 clk = ~clk;

    logic [N*4-1:0]  s_awid, s_arid;
    logic [N*32-1:0] s_awaddr, s_araddr;
    logic [N*8-1:0]  s_awlen, s_arlen;
    logic [N*3-1:0]  s_awsize, s_arsize;
    logic [N*2-1:0]  s_awburst, s_arburst;
    logic [N-1:0]    s_awvalid, s_awready, s_arvalid, s_arready;
    logic [N*64-1:0] s_wdata;
    logic [N*8-1:0]  s_wstrb;
    logic [N-1:0]    s_wlast, s_wvalid, s_wready;
    logic [3:0]      s_bid, s_rid;
    logic [1:0]      s_bresp, s_rresp;
    logic [N-1:0]    s_bvalid, s_bready, s_rvalid, s_rready;
    logic [63:0]     s_rdata;
    logic            s_rlast;
    logic [3:0]      m_awid, m_arid, m_bid, m_rid;
    logic [31:0]     m_awaddr, m_araddr;
    logic [7:0]      m_awlen, m_arlen;
    logic [2:0]      m_awsize, m_arsize, m_awprot, m_arprot;
    logic [1:0]      m_awburst, m_arburst, m_bresp, m_rresp;
    logic            m_awlock, m_arlock;
    logic [3:0]      m_awcache, m_arcache, m_awqos, m_arqos;
    logic            m_awvalid, m_awready, m_arvalid, m_arready;
    logic [63:0]     m_wdata, m_rdata;
    logic [7:0]      m_wstrb;
    logic            m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
    logic            m_rlast, m_rvalid, m_rready;
    logic [N-1:0]    err_wlast;
    logic            wr_busy, rd_busy;

    mig_axi_port_arbiter #(.NUM_PORTS(N), .ADDR_W(32), .DATA_W(64), .ID_W(4)) dut (
        .mig_ui_clk(clk), .mig_ui_rst(mig_ui_rst),
        .s_awid_i(s_awid), .s_awaddr_i(s_awaddr), .s_awlen_i(s_awlen), .s_awsize_i(s_awsize),
        .s_awburst_i(s_awburst), .s_awvalid_i(s_awvalid), .s_awready_o(s_awready),
        .s_wdata_i(s_wdata), .s_wstrb_i(s_wstrb), .s_wlast_i(s_wlast),
        .s_wvalid_i(s_wvalid), .s_wready_o(s_wready),
        .s_bid_o(s_bid), .s_bresp_o(s_bresp), .s_bvalid_o(s_bvalid), .s_bready_i(s_bready),
        .s_arid_i(s_arid), .s_araddr_i(s_araddr), .s_arlen_i(s_arlen), .s_arsize_i(s_arsize),
        .s_arburst_i(s_arburst), .s_arvalid_i(s_arvalid), .s_arready_o(s_arready),
        .s_rid_o(s_rid), .s_rdata_o(s_rdata), .s_rresp_o(s_rresp), .s_rlast_o(s_rlast),
        .s_rvalid_o(s_rvalid), .s_rready_i(s_rready),
        .mig_s_axi_awid_o(m_awid), .mig_s_axi_awaddr_o(m_awaddr), .mig_s_axi_awlen_o(m_awlen),
        .mig_s_axi_awsize_o(m_awsize), .mig_s_axi_awburst_o(m_awburst),
        .mig_s_axi_awlock_o(m_awlock), .mig_s_axi_awcache_o(m_awcache),
        .mig_s_axi_awprot_o(m_awprot), .mig_s_axi_awqos_o(m_awqos),
        .mig_s_axi_awvalid_o(m_awvalid), .mig_s_axi_awready_i(m_awready),
        .mig_s_axi_wdata_o(m_wdata), .mig_s_axi_wstrb_o(m_wstrb), .mig_s_axi_wlast_o(m_wlast),
        .mig_s_axi_wvalid_o(m_wvalid), .mig_s_axi_wready_i(m_wready),
        .mig_s_axi_bid_i(m_bid), .mig_s_axi_bresp_i(m_bresp), .mig_s_axi_bvalid_i(m_bvalid),
        .mig_s_axi_bready_o(m_bready),
        .mig_s_axi_arid_o(m_arid), .mig_s_axi_araddr_o(m_araddr), .mig_s_axi_arlen_o(m_arlen),
        .mig_s_axi_arsize_o(m_arsize), .mig_s_axi_arburst_o(m_arburst),
        .mig_s_axi_arlock_o(m_arlock), .mig_s_axi_arcache_o(m_arcache),
        .mig_s_axi_arprot_o(m_arprot), .mig_s_axi_arqos_o(m_arqos),
        .mig_s_axi_arvalid_o(m_arvalid), .mig_s_axi_arready_i(m_arready),
        .mig_s_axi_rid_i(m_rid), .mig_s_axi_rdata_i(m_rdata), .mig_s_axi_rresp_i(m_rresp),
        .mig_s_axi_rlast_i(m_rlast), .mig_s_axi_rvalid_i(m_rvalid),
        .mig_s_axi_rready_o(m_rready),
        .err_wlast_o(err_wlast), .wr_busy_o(wr_busy), .rd_busy_o(rd_busy)
    );

    int          n_checks = 0, n_fails = 0;
    int          w_lastg, r_lastg;
    logic [N-1:0] errm;
    int          cfg_wlen[N], cfg_rlen[N];
    bit          cfg_corrupt[N];
    logic [31:0] salt;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_next(input int last, input logic [N-1:0] m);
        for (int i = 1; i <= N; i++) begin
            int q;
            q = (last + i) % N;
            if (m[q]) return q;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int p);
        logic [N-1:0] v;
        v = '0;
        if (p >= 0) v[p] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] wdat(input int p, input int b);
        return {8'(p), 8'(b), 16'h5A00, salt};
    endfunction
    function automatic logic [7:0] wstb(input int p, input int b);
        return 8'(p * 37 + b * 11 + 1);
    endfunction
    function automatic logic [31:0] waddr(input int p);
        return {8'(p), salt[23:0]};
    endfunction
    function automatic logic [31:0] raddr(input int p);
        return {8'(p + 128), salt[23:0]};
    endfunction

    task automatic drive_idle();
        s_awvalid = '0; s_arvalid = '0; s_wvalid = '0; s_wlast = '0; s_wdata = '0;
        s_wstrb = '0; s_bready = '0; s_rready = '0;
        m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_bid = '0; m_bresp = '0;
        m_rvalid = 0; m_rlast = 0; m_rdata = '0; m_rid = '0; m_rresp = '0;
    endtask

    task automatic set_fields();
        salt = $urandom;
        for (int p = 0; p < N; p++) begin
            s_awid[p*4 +: 4]    = 4'(p + 1);
            s_awaddr[p*32 +: 32] = waddr(p);
            s_awlen[p*8 +: 8]   = 8'(cfg_wlen[p]);
            s_awsize[p*3 +: 3]  = 3'(p);
            s_awburst[p*2 +: 2] = 2'b01;
            s_arid[p*4 +: 4]    = 4'(p + 9);
            s_araddr[p*32 +: 32] = raddr(p);
            s_arlen[p*8 +: 8]   = 8'(cfg_rlen[p]);
            s_arsize[p*3 +: 3]  = 3'(p + 2);
            s_arburst[p*2 +: 2] = 2'b10;
        end
    endtask

    task automatic clear_cfg();
        for (int p = 0; p < N; p++) begin
            cfg_wlen[p] = 0; cfg_rlen[p] = 0; cfg_corrupt[p] = 0;
        end
    endtask

    // One round: every port in wmask/rmask issues one burst; all run to completion.
    task automatic run_round(input logic [N-1:0] wmask, input logic [N-1:0] rmask);
        logic [N-1:0] w_pend, r_pend, amask, armask;
        int mwp, mwbeat, bdly, mrp, mrbeat, w_todo, r_todo, cyc, ew, er;
        bit wdone;
        logic [3:0] bid_x;
        logic [1:0] bresp_x;
        set_fields();
        w_pend = wmask; r_pend = rmask;
        mwp = -1; mrp = -1; mwbeat = 0; mrbeat = 0; bdly = 0; wdone = 0;
        bid_x = '0; bresp_x = '0;
        w_todo = $countones(wmask); r_todo = $countones(rmask); cyc = 0;
        for (int p = 0; p < N; p++) if (wmask[p] && cfg_corrupt[p]) errm[p] = 1'b1;
        while (w_todo + r_todo > 0) begin
            if (cyc >= 4000) begin
                check_eq("round_timeout", 1, 0);
                break;
            end
            @(posedge clk); #1;
            s_awvalid = w_pend;
            s_arvalid = r_pend;
            for (int p = 0; p < N; p++) begin
                s_wvalid[p] = 1'($urandom_range(0, 1));
                s_wdata[p*64 +: 64] = {$urandom, $urandom};
                s_wstrb[p*8 +: 8] = 8'($urandom);
                s_wlast[p] = 1'($urandom_range(0, 1));
            end
            if (mwp >= 0 && !wdone) begin
                s_wvalid[mwp] = ($urandom_range(0, 3) != 0);
                s_wdata[mwp*64 +: 64] = wdat(mwp, mwbeat);
                s_wstrb[mwp*8 +: 8] = wstb(mwp, mwbeat);
                s_wlast[mwp] = (mwbeat == cfg_wlen[mwp]) ^ (cfg_corrupt[mwp] && mwbeat == 0);
            end
            s_bready = N'($urandom);
            s_rready = N'($urandom);
            m_awready = 1'($urandom_range(0, 1));
            m_arready = 1'($urandom_range(0, 1));
            m_wready = ($urandom_range(0, 3) != 0);
            m_bvalid = (mwp >= 0) && wdone && (bdly == 0);
            m_bid = bid_x; m_bresp = bresp_x;
            m_rvalid = (mrp >= 0) && ($urandom_range(0, 3) != 0);
            m_rdata = {$urandom, $urandom}; m_rid = 4'($urandom); m_rresp = 2'($urandom);
            m_rlast = (mrp >= 0) && (mrbeat == cfg_rlen[mrp]);
            #1;
            ew = rr_next(w_lastg, w_pend);
            er = rr_next(r_lastg, r_pend);
            amask  = (mwp < 0) ? oh(ew) : '0;
            armask = (mrp < 0) ? oh(er) : '0;
            if (cyc == 0) begin
                check_eq("aw_not_same_cycle", m_awvalid, 0);
                check_eq("ar_not_same_cycle", m_arvalid, 0);
            end else if (cyc == 1) begin
                check_eq("aw_latency", m_awvalid, |wmask);
                check_eq("ar_latency", m_arvalid, |rmask);
            end
            check_eq("awready_route", s_awready & ~amask, 0);
            check_eq("arready_route", s_arready & ~armask, 0);
            check_eq("wready_route", s_wready & ~((mwp >= 0 && !wdone) ? oh(mwp) : '0), 0);
            check_eq("bvalid_route", s_bvalid, m_bvalid ? oh(mwp) : '0);
            check_eq("bready_pass", m_bready, (mwp >= 0 && wdone) ? s_bready[mwp] : 1'b0);
            check_eq("b_pass", {s_bid, s_bresp}, {m_bid, m_bresp});
            check_eq("rvalid_route", s_rvalid, m_rvalid ? oh(mrp) : '0);
            check_eq("rready_pass", m_rready, (mrp >= 0) ? s_rready[mrp] : 1'b0);
            check_eq("r_pass", {s_rid, s_rdata, s_rresp, s_rlast},
                     {m_rid, m_rdata, m_rresp, m_rlast});
            // B and R completions first; new grants only affect the next cycle.
            if (m_bvalid && m_bready) begin
                mwp = -1; wdone = 0; w_todo--;
            end
            if (m_rvalid && m_rready && mrp >= 0) begin
                if (m_rlast) begin
                    mrp = -1; r_todo--;
                end
                mrbeat++;
            end
            if (m_wvalid && m_wready) begin
                check_eq("w_expected", (mwp >= 0) && !wdone, 1);
                if (mwp >= 0 && !wdone) begin
                    check_eq("w_data", m_wdata, wdat(mwp, mwbeat));
                    check_eq("w_strb", m_wstrb, wstb(mwp, mwbeat));
                    check_eq("w_last", m_wlast, mwbeat == cfg_wlen[mwp]);
                    check_eq("w_src_hs", s_wready & s_wvalid, oh(mwp));
                    if (mwbeat == cfg_wlen[mwp]) begin
                        wdone = 1; bdly = $urandom_range(0, 3);
                        bid_x = 4'($urandom); bresp_x = 2'($urandom);
                    end
                    mwbeat++;
                end
            end else if (mwp >= 0 && wdone && bdly > 0) begin
                bdly--;
            end
            if (m_awvalid && m_awready) begin
                check_eq("aw_grant_exists", ew >= 0, 1);
                if (ew >= 0) begin
                    check_eq("aw_fields", {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst},
                             {4'(ew + 1), waddr(ew), 8'(cfg_wlen[ew]), 3'(ew), 2'b01});
                    check_eq("aw_const", {m_awlock, m_awcache, m_awprot, m_awqos},
                             {1'b0, 4'b0011, 3'b000, 4'b0000});
                    check_eq("aw_src_hs", s_awready & s_awvalid, oh(ew));
                    w_pend[ew] = 1'b0; w_lastg = ew; mwp = ew; mwbeat = 0; wdone = 0;
                end
            end
            if (m_arvalid && m_arready) begin
                check_eq("ar_grant_exists", er >= 0, 1);
                if (er >= 0) begin
                    check_eq("ar_fields", {m_arid, m_araddr, m_arlen, m_arsize, m_arburst},
                             {4'(er + 9), raddr(er), 8'(cfg_rlen[er]), 3'(er + 2), 2'b10});
                    check_eq("ar_const", {m_arlock, m_arcache, m_arprot, m_arqos},
                             {1'b0, 4'b0011, 3'b000, 4'b0000});
                    check_eq("ar_src_hs", s_arready & s_arvalid, oh(er));
                    r_pend[er] = 1'b0; r_lastg = er; mrp = er; mrbeat = 0;
                end
            end
            cyc++;
        end
        @(posedge clk); #1;
        drive_idle();
        #1;
        check_eq("busy_after_round", {wr_busy, rd_busy}, 2'b00);
        check_eq("err_wlast", err_wlast, errm);
    endtask

    initial begin
        mig_ui_rst = 1'b1;
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
        drive_idle();
        clear_cfg();
        w_lastg = N - 1; r_lastg = N - 1; errm = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valids", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
        check_eq("rst_readies", {s_awready, s_wready, s_bvalid, s_arready, s_rvalid}, 0);
        check_eq("rst_status", {err_wlast, wr_busy, rd_busy}, 0);
        check_eq("rst_data", {m_awaddr, m_wdata, m_araddr, m_wlast}, 0);
        mig_ui_rst = 1'b0;

        clear_cfg(); cfg_wlen[1] = 3;
        run_round(3'b010, 3'b000);
        clear_cfg();
        run_round(3'b000, 3'b011);
        for (int k = 0; k < 2; k++) begin
            clear_cfg(); cfg_wlen[0] = 2; cfg_wlen[1] = 1;
            run_round(3'b011, 3'b000);
        end
        clear_cfg(); cfg_wlen[0] = 1; cfg_rlen[1] = 2;
        run_round(3'b001, 3'b010);
        clear_cfg(); cfg_wlen[0] = 1; cfg_corrupt[0] = 1;
        run_round(3'b001, 3'b000);
        clear_cfg(); cfg_wlen[2] = 255; cfg_rlen[2] = 255;
        run_round(3'b100, 3'b100);

        // Reset in the middle of a len=7 read, during beat 2.
        clear_cfg(); cfg_rlen[0] = 7;
        set_fields();
        @(posedge clk); #1;
        s_arvalid = 3'b001; m_arready = 1'b1; s_rready = '1;
        @(posedge clk); #2;
        check_eq("rst_test_ar", {m_arvalid, m_araddr}, {1'b1, raddr(0)});
        @(posedge clk); #1;
        s_arvalid = '0; m_arready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b0;
        @(posedge clk); #2;
        check_eq("rst_test_beat2", s_rvalid, 3'b001);
        mig_ui_rst = 1'b1;
        #1;
        check_eq("rst_mid_outs", {s_rvalid, m_rready, s_arready, m_arvalid, rd_busy}, 0);
        check_eq("rst_mid_err", err_wlast, 0);
        @(posedge clk); #1;
        mig_ui_rst = 1'b0;
        drive_idle();
        w_lastg = N - 1; r_lastg = N - 1; errm = '0;
        clear_cfg(); cfg_rlen[0] = 7; cfg_rlen[1] = 1; cfg_wlen[2] = 2;
        run_round(3'b100, 3'b011);

        for (int k = 0; k < 20; k++) begin
            logic [N-1:0] wm, rm;
            clear_cfg();
            wm = N'($urandom); rm = N'($urandom);
            for (int p = 0; p < N; p++) begin
                cfg_wlen[p] = $urandom_range(0, 7);
                cfg_rlen[p] = $urandom_range(0, 7);
                cfg_corrupt[p] = ($urandom_range(0, 5) == 0);
            end
            run_round(wm, rm);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule
